// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin arbiter in front of an SRAM controller
module sram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Index of the final ACCESS cycle; strobes span cycles 0..C_LAST.
  localparam logic [3:0] C_LAST = 4'(ACCESS_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_win;
  logic                r_we;
  logic                r_last;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_capture;
  logic                w_pick;
  logic                w_last_cycle;

  // Next-state and arbitration decision; a tie goes to whoever was not served last.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_pick       = (req0 && req1) ? ~r_last : req1;
    w_last_cycle = (r_state == S_ACCESS) && (r_cnt == C_LAST);
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_next    = S_ACCESS;
          w_capture = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == C_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ACCESS cycle counter, cleared whenever not in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Capture winner, direction, address and write data when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win         <= 1'b0;
      r_we          <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else if (w_capture) begin
      r_win         <= w_pick;
      r_we          <= w_pick ? we1 : we0;
      r_mem_address <= w_pick ? addr1 : addr0;
      r_mem_wdata   <= w_pick ? wdata1 : wdata0;
    end
  end

  // Sample read data at the end of the last ACCESS cycle into the winner's holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_last_cycle && !r_we) begin
      if (r_win) begin
        r_rdata1 <= mem_rdata;
      end else begin
        r_rdata0 <= mem_rdata;
      end
    end
  end

  // Last-served pointer; starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_last <= r_win;
    end
  end

  // Grant is the first ACCESS cycle; ack is the DONE cycle; strobes decode from state.
  assign gnt0             = (r_state == S_ACCESS) && (r_cnt == 4'd0) && !r_win;
  assign gnt1             = (r_state == S_ACCESS) && (r_cnt == 4'd0) &&  r_win;
  assign ack0             = (r_state == S_DONE) && !r_win;
  assign ack1             = (r_state == S_DONE) &&  r_win;
  assign mem_read_enable  = (r_state == S_ACCESS) && !r_we;
  assign mem_write_enable = (r_state == S_ACCESS) &&  r_we;
  assign mem_address      = r_mem_address;
  assign mem_wdata        = r_mem_wdata;
  assign rdata0           = r_rdata0;
  assign rdata1           = r_rdata1;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;

  logic        gnt0, gnt1, ack0, ack1, mem_re, mem_we, busy;
  logic [7:0]  rdata0, rdata1, mem_wdata, mem_rdata;
  logic [15:0] mem_address;

  logic        a1_gnt0, a1_gnt1, a1_ack0, a1_ack1, a1_re, a1_we, a1_busy;
  logic [7:0]  a1_rdata0, a1_rdata1, a1_wdata;
  logic [15:0] a1_addr;
  logic        a4_gnt0, a4_gnt1, a4_ack0, a4_ack1, a4_re, a4_we, a4_busy;
  logic [7:0]  a4_rdata0, a4_rdata1, a4_wdata;
  logic [15:0] a4_addr;
  logic [7:0]  fixed_rdata = 8'h5A;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_address[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_address[7:0]];

  sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read_enable(mem_re), .mem_write_enable(mem_we), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(1)) dut_a1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a1_gnt0), .gnt1(a1_gnt1), .ack0(a1_ack0), .ack1(a1_ack1),
    .rdata0(a1_rdata0), .rdata1(a1_rdata1), .mem_read_enable(a1_re), .mem_write_enable(a1_we),
    .mem_address(a1_addr), .mem_wdata(a1_wdata), .mem_rdata(fixed_rdata), .busy(a1_busy));

  sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(4)) dut_a4 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a4_gnt0), .gnt1(a4_gnt1), .ack0(a4_ack0), .ack1(a4_ack1),
    .rdata0(a4_rdata0), .rdata1(a4_rdata1), .mem_read_enable(a4_re), .mem_write_enable(a4_we),
    .mem_address(a4_addr), .mem_wdata(a4_wdata), .mem_rdata(fixed_rdata), .busy(a4_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] order [4];
    int ng, overlap, gapviol, w1, w2, w4, k1, k2, k4;
    logic prev_ack;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset state, asynchronous
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_re, mem_we}, 0);
    chk("rst_gnt_ack", {gnt0, gnt1, ack0, ack1}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    step(); step();
    chk("rst_held_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // single write from requester 0
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 8'hAA;
    step();
    chk("w_gnt0", gnt0, 1);
    chk("w_gnt1", gnt1, 0);
    chk("w_we_c1", mem_we, 1);
    chk("w_re_c1", mem_re, 0);
    chk("w_addr", mem_address, 16'h0010);
    chk("w_wdata", mem_wdata, 8'hAA);
    req0 = 0;
    step();
    chk("w_gnt0_off", gnt0, 0);
    chk("w_we_c2", mem_we, 1);
    chk("w_ack_early", ack0, 0);
    step();
    chk("w_ack0", ack0, 1);
    chk("w_ack1", ack1, 0);
    chk("w_we_done", mem_we, 0);
    chk("w_busy_done", busy, 1);
    step();
    chk("w_idle_busy", busy, 0);
    chk("w_idle_ack", ack0, 0);
    chk("w_addr_hold", mem_address, 16'h0010);

    // single read from requester 1
    req1 = 1; we1 = 0; addr1 = 16'h0010;
    step();
    chk("r_gnt1", gnt1, 1);
    chk("r_re_c1", mem_re, 1);
    chk("r_we_c1", mem_we, 0);
    req1 = 0;
    step();
    chk("r_re_c2", mem_re, 1);
    step();
    chk("r_ack1", ack1, 1);
    chk("r_rdata1", rdata1, 8'hAA);
    chk("r_rdata0", rdata0, 8'h00);
    chk("r_re_done", mem_re, 0);
    step();
    chk("r_rdata1_hold", rdata1, 8'hAA);

    // both requesters held from reset: alternation
    rst_n = 0; step();
    @(negedge clk) rst_n = 1'b1;
    step();
    req0 = 1; we0 = 1; addr0 = 16'h0020; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 16'h0021; wdata1 = 8'h22;
    ng = 0; overlap = 0; gapviol = 0; prev_ack = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (gnt0 || gnt1) begin
        if (ng < 4) order[ng] = {1'b0, gnt1};
        ng++;
      end
      if (mem_re && mem_we) overlap++;
      if ((gnt0 && gnt1) || (ack0 && ack1)) overlap++;
      if (prev_ack && busy) gapviol++;
      prev_ack = ack0 | ack1;
    end
    req0 = 0; req1 = 0;
    chk("rr_count", ng, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    chk("rr_overlap", overlap, 0);
    chk("rr_idle_gap", gapviol, 0);
    step();

    // reset in the second ACCESS cycle of a write
    req0 = 1; we0 = 1; addr0 = 16'h0030; wdata0 = 8'h77;
    step();
    chk("ra_gnt0", gnt0, 1);
    req0 = 0;
    step();
    chk("ra_we_c2", mem_we, 1);
    rst_n = 0;
    #1;
    chk("ra_we_drop", mem_we, 0);
    chk("ra_busy_drop", busy, 0);
    chk("ra_addr_clr", mem_address, 0);
    step();
    chk("ra_no_ack", {ack0, ack1}, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("ra_idle", busy, 0);
    req1 = 1; we1 = 1; addr1 = 16'h0031; wdata1 = 8'h55;
    step();
    chk("ra_gnt1", gnt1, 1);
    chk("ra_we_new", mem_we, 1);
    chk("ra_addr_new", mem_address, 16'h0031);
    req1 = 0;
    step(); step();
    chk("ra_ack1", ack1, 1);
    chk("ra_ack0", ack0, 0);
    step();

    // request dropped and address changed after grant
    req1 = 1; we1 = 0; addr1 = 16'h0021;
    step();
    chk("dr_gnt1", gnt1, 1);
    step();
    req1 = 0; addr1 = 16'h00FF; we1 = 1;
    chk("dr_addr", mem_address, 16'h0021);
    chk("dr_re", mem_re, 1);
    step();
    chk("dr_ack1", ack1, 1);
    chk("dr_rdata1", rdata1, 8'h22);
    chk("dr_rdata0", rdata0, 8'h00);
    step();

    // strobe width and ack latency for 1, 2 and 4 cycle builds
    rst_n = 0; step();
    @(negedge clk) rst_n = 1'b1;
    step();
    req0 = 1; we0 = 1; addr0 = 16'h0040; wdata0 = 8'h99;
    step();
    req0 = 0;
    w1 = 0; w2 = 0; w4 = 0; k1 = 0; k2 = 0; k4 = 0;
    for (int k = 1; k <= 7; k++) begin
      if (a1_we) w1++;
      if (mem_we) w2++;
      if (a4_we) w4++;
      if (a1_ack0 && k1 == 0) k1 = k;
      if (ack0 && k2 == 0) k2 = k;
      if (a4_ack0 && k4 == 0) k4 = k;
      step();
    end
    chk("ac1_width", w1, 1);
    chk("ac1_latency", k1, 2);
    chk("ac2_width", w2, 2);
    chk("ac2_latency", k2, 3);
    chk("ac4_width", w4, 4);
    chk("ac4_latency", k4, 5);
    chk("ac_idle_end", {a1_busy, busy, a4_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
